// File: rtl/logic_func_tester.sv
// Sweeps a 3-input block through vectors 000..111 and compares each response with a latched golden table.
// Done follows the start-accept edge by 8*(SETTLE_CYCLES+1) cycles; start is ignored while busy.
module logic_func_tester #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       dut_y,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail_idx,
    output logic       first_fail_valid
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] exp_q, exp_d;
    logic [3:0] err_q, err_d;
    logic [2:0] ffi_q, ffi_d;
    logic       ffv_q, ffv_d;
    logic       pass_q, pass_d;
    logic       mism;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            exp_q   <= 8'd0;
            err_q   <= 4'd0;
            ffi_q   <= 3'd0;
            ffv_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
            ffi_q   <= ffi_d;
            ffv_q   <= ffv_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        err_d   = err_q;
        ffi_d   = ffi_q;
        ffv_d   = ffv_q;
        pass_d  = pass_q;
        mism    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    exp_d   = expected;
                    idx_d   = 3'd0;
                    err_d   = 4'd0;
                    ffi_d   = 3'd0;
                    ffv_d   = 1'b0;
                    pass_d  = 1'b0;
                    cnt_d   = SETTLE_LOAD;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SAMPLE: begin
                mism = (dut_y != exp_q[idx_q]);
                if (mism && (err_q != 4'd8)) begin
                    err_d = err_q + 4'd1;
                end
                if (mism && !ffv_q) begin
                    ffi_d = idx_q;
                    ffv_d = 1'b1;
                end
                // Pass uses the updated count so a miss on the last vector is not lost.
                if (idx_q == 3'd7) begin
                    pass_d  = (err_d == 4'd0);
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = SETTLE_LOAD;
                    state_d = S_SETTLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dut_a            = idx_q[2];
    assign dut_b            = idx_q[1];
    assign dut_c            = idx_q[0];
    assign busy             = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign done             = (state_q == S_DONE);
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_idx   = ffi_q;
    assign first_fail_valid = ffv_q;

endmodule
